// File: rtl/demux1x2_stream.sv
// Packet-aware 1-to-2 stream demultiplexer with a small FWFT FIFO per output.
// The route is locked for the whole packet so that beats of one packet never split across outputs.
module demux1x2_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             busy,
  output logic [7:0]       pkt0_cnt,
  output logic [7:0]       pkt1_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             route_q, route_d;
  logic             dest;
  logic             accept;
  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       pop_rdy;
  logic [1:0]       head_last;
  logic [WIDTH-1:0] head_data [2];
  logic [7:0]       cnt [2];

  assign pop_rdy = {out1_ready, out0_ready};

  // s only matters on the first beat; mid-packet the latched route wins
  always_comb begin
    dest = s;
    if (state_q == LOCK) dest = route_q;
  end

  assign in_ready = !full[dest];
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q == LOCK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d = LOCK;
          route_d = s;
        end
      end
      LOCK: begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar k = 0; k < 2; k++) begin : g_fifo
    logic [WIDTH:0]  mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [7:0]      cnt_q;

    assign full[k]  = (count_q == CW'(DEPTH));
    assign empty[k] = (count_q == '0);
    assign push[k]  = accept & (dest == 1'(k));
    assign pop[k]   = !empty[k] & pop_rdy[k];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        cnt_q    <= '0;
      end else begin
        if (push[k]) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop[k])  rd_ptr_q <= rd_ptr_q + PW'(1);
        if (push[k] && !pop[k])      count_q <= count_q + CW'(1);
        else if (!push[k] && pop[k]) count_q <= count_q - CW'(1);
        if (push[k] && in_last) cnt_q <= cnt_q + 8'd1;
      end
    end

    // Storage needs no reset: the head is masked to zero while empty
    always_ff @(posedge clk) begin
      if (push[k]) mem_q[wr_ptr_q] <= {in_last, in_data};
    end

    assign head_data[k] = empty[k] ? '0 : mem_q[rd_ptr_q][WIDTH-1:0];
    assign head_last[k] = empty[k] ? 1'b0 : mem_q[rd_ptr_q][WIDTH];
    assign cnt[k]       = cnt_q;
  end

  assign out0_data  = head_data[0];
  assign out0_last  = head_last[0];
  assign out0_valid = !empty[0];
  assign out1_data  = head_data[1];
  assign out1_last  = head_last[1];
  assign out1_valid = !empty[1];
  assign pkt0_cnt   = cnt[0];
  assign pkt1_cnt   = cnt[1];

endmodule

// File: tb/tb_demux1x2_stream.sv
// Scoreboard bench for demux1x2_stream: a reference model of the route lock and
// per-output queues checks every output on each falling edge.
module tb_demux1x2_stream;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;

  logic             clk;
  logic             rst;
  logic             s;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             out0_last, out1_last;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic             busy;
  logic [7:0]       pkt0_cnt, pkt1_cnt;

  int unsigned n_tests;
  int unsigned n_fail;
  logic        last_acc;

  logic [WIDTH:0] q0 [$];
  logic [WIDTH:0] q1 [$];
  logic           m_lock;
  logic           m_route;
  logic [7:0]     m_cnt0, m_cnt1;

  demux1x2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (s),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .busy       (busy),
    .pkt0_cnt   (pkt0_cnt),
    .pkt1_cnt   (pkt1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: evaluated on the falling edge, i.e. the state before the next rising edge
  always @(negedge clk) begin : model
    logic           d;
    logic [WIDTH:0] h;
    last_acc = 1'b0;
    if (rst) begin
      check("rst_v0", 32'(out0_valid), 32'd0);
      check("rst_v1", 32'(out1_valid), 32'd0);
      check("rst_d0", 32'(out0_data), 32'd0);
      check("rst_d1", 32'(out1_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_c0", 32'(pkt0_cnt), 32'd0);
      check("rst_c1", 32'(pkt1_cnt), 32'd0);
      check("rst_rdy", 32'(in_ready), 32'd1);
      q0.delete();
      q1.delete();
      m_lock  = 1'b0;
      m_route = 1'b0;
      m_cnt0  = '0;
      m_cnt1  = '0;
    end else begin
      d = m_lock ? m_route : s;
      check("in_ready", 32'(in_ready), 32'((d ? q1.size() : q0.size()) < DEPTH));
      h = (q0.size() > 0) ? q0[0] : '0;
      check("out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
      check("out0_data", 32'(out0_data), 32'(h[WIDTH-1:0]));
      check("out0_last", 32'(out0_last), 32'(h[WIDTH]));
      h = (q1.size() > 0) ? q1[0] : '0;
      check("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
      check("out1_data", 32'(out1_data), 32'(h[WIDTH-1:0]));
      check("out1_last", 32'(out1_last), 32'(h[WIDTH]));
      check("busy", 32'(busy), 32'(m_lock));
      check("pkt0_cnt", 32'(pkt0_cnt), 32'(m_cnt0));
      check("pkt1_cnt", 32'(pkt1_cnt), 32'(m_cnt1));
      if (out0_valid && out0_ready && q0.size() > 0) void'(q0.pop_front());
      if (out1_valid && out1_ready && q1.size() > 0) void'(q1.pop_front());
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        if (d) q1.push_back({in_last, in_data});
        else   q0.push_back({in_last, in_data});
        if (in_last) begin
          if (d) m_cnt1 = m_cnt1 + 8'd1;
          else   m_cnt0 = m_cnt0 + 8'd1;
          m_lock = 1'b0;
        end else if (!m_lock) begin
          m_lock  = 1'b1;
          m_route = s;
        end
      end
    end
  end

  // Presents one beat and returns #1 after the edge that accepted it
  task automatic send_beat(input logic [7:0] dat, input logic sel, input logic last,
                           output int unsigned waited);
    in_data  = dat;
    s        = sel;
    in_last  = last;
    in_valid = 1'b1;
    waited   = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!last_acc && waited < 50);
    if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    s          = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-packet
    send_beat(8'h01, 1'b0, 1'b0, w);
    send_beat(8'h02, 1'b0, 1'b0, w);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_v0", 32'(out0_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send_beat(8'hA5, 1'b1, 1'b1, w);
    check("a5_wait", w, 32'd1);
    check("a5_valid", 32'(out1_valid), 32'd1);
    check("a5_data", 32'(out1_data), 32'hA5);
    check("a5_cnt", 32'(pkt1_cnt), 32'd1);
    check("a5_v0", 32'(out0_valid), 32'd0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    idle(3);

    // Packet lock: s toggles after the first beat but is ignored
    send_beat(8'h10, 1'b0, 1'b0, w);
    check("lock_busy1", 32'(busy), 32'd1);
    send_beat(8'h11, 1'b1, 1'b0, w);
    check("lock_busy2", 32'(busy), 32'd1);
    send_beat(8'h12, 1'b1, 1'b0, w);
    check("lock_busy3", 32'(busy), 32'd1);
    send_beat(8'h13, 1'b1, 1'b1, w);
    check("lock_busy4", 32'(busy), 32'd0);
    check("lock_cnt0", 32'(pkt0_cnt), 32'd1);
    idle(3);

    // Back-pressure isolation
    out0_ready = 1'b0;
    send_beat(8'h20, 1'b0, 1'b1, w);
    send_beat(8'h21, 1'b0, 1'b1, w);
    s        = 1'b0;
    in_valid = 1'b1;
    #1;
    check("bp_ready0", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    send_beat(8'h30, 1'b1, 1'b1, w);
    check("bp_wait1", w, 32'd1);
    check("bp_v1", 32'(out1_valid), 32'd1);
    check("bp_d1", 32'(out1_data), 32'h30);

    // Full destination with a same-cycle pop: no pass-through
    out0_ready = 1'b1;
    in_data    = 8'h22;
    s          = 1'b0;
    in_last    = 1'b1;
    in_valid   = 1'b1;
    #1;
    check("fp_ready", 32'(in_ready), 32'd0);
    send_beat(8'h22, 1'b0, 1'b1, w);
    check("fp_wait", w, 32'd2);
    idle(5);

    // Counter wrap on out1
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      send_beat(8'(i), 1'b1, 1'b1, w);
      if (i == 254) check("wrap_255", 32'(pkt1_cnt), 32'd255);
    end
    check("wrap_0", 32'(pkt1_cnt), 32'd0);
    idle(4);

    // Random stress
    for (int c = 0; c < 10000; c++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(3) != 0);
        in_data  = 8'($urandom);
        in_last  = ($urandom_range(2) == 0);
        s        = 1'($urandom_range(1));
      end
      out0_ready = ($urandom_range(3) != 0);
      out1_ready = ($urandom_range(2) != 0);
      @(posedge clk);
      #1;
    end
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    idle(2 * DEPTH + 4);
    check("drain_q0", q0.size(), 32'd0);
    check("drain_q1", q1.size(), 32'd0);
    check("drain_v0", 32'(out0_valid), 32'd0);
    check("drain_v1", 32'(out1_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
